bit_scan_pipe: RTL and testbench

Parametrised, pipelined bit-scan unit: finds the position of the most significant or least significant set bit of an N-bit word, selectable per transaction. Successor to the single-cycle N-bit MSB finder; adds LSB mode, an all-zero flag, a two-stage group/select pipeline for wide N, and valid/ready flow control on both sides. Sits between a data producer and any consumer needing normalisation shifts or priority selection.

---
 rtl/bit_scan_pipe.sv | 138 +++++++++++++
 tb/tb_bit_scan_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_pipe.sv
// bit_scan_pipe: two-stage pipelined MSB/LSB finder with valid/ready flow control.
// Stage 1 reduces each G-bit group to a nonzero flag plus a local index.
// Stage 2 picks the winning group and forms the absolute bit position.
module bit_scan_pipe #(
  parameter int N = 64,
  parameter int G = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] input_num,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] output_pos,
  output logic         output_zero,
  output logic         output_mode
);

  localparam int NG = N / G;
  localparam int LG = $clog2(G);

  // Stage 1 combinational group results, computed from the raw input.
  logic [NG-1:0]    grp_nz_d;
  logic [NG*LG-1:0] grp_li_d;

  // Stage 1 register (S1).
  logic             v1_q;
  logic [NG-1:0]    s1_nz_q;
  logic [NG*LG-1:0] s1_li_q;
  logic             s1_mode_q;

  // Stage 2 register (S2), which drives the outputs directly.
  logic             v2_q;
  logic [W-1:0]     s2_pos_q;
  logic             s2_zero_q;
  logic             s2_mode_q;

  // Stage 2 combinational selection from S1.
  logic [W-1:0]     sel_pos_d;
  logic             sel_zero_d;

  // Handshake control.
  logic             in_xfer;
  logic             s2_load;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      logic [G-1:0]  bits;
      logic [LG-1:0] li;

      assign bits = input_num[gi*G +: G];
      assign grp_nz_d[gi] = |bits;
      assign grp_li_d[gi*LG +: LG] = li;

      // Local priority encode: the last match in scan order wins.
      always_comb begin
        li = '0;
        if (mode) begin
          for (int j = G - 1; j >= 0; j--) begin
            if (bits[j]) li = LG'(j);
          end
        end else begin
          for (int j = 0; j < G; j++) begin
            if (bits[j]) li = LG'(j);
          end
        end
      end
    end
  endgenerate

  // Group selection: highest nonzero group for MSB, lowest for LSB.
  always_comb begin
    sel_pos_d  = '0;
    sel_zero_d = ~|s1_nz_q;
    if (s1_mode_q) begin
      for (int k = NG - 1; k >= 0; k--) begin
        if (s1_nz_q[k]) sel_pos_d = W'(k * G) + W'(s1_li_q[k*LG +: LG]);
      end
    end else begin
      for (int k = 0; k < NG; k++) begin
        if (s1_nz_q[k]) sel_pos_d = W'(k * G) + W'(s1_li_q[k*LG +: LG]);
      end
    end
  end

  // S2 accepts whenever it is empty or its result leaves this cycle;
  // S1 is then free to take a new word on the same edge.
  assign s2_load  = v1_q & (~v2_q | out_ready);
  assign in_ready = ~v1_q | ~v2_q | out_ready;
  assign in_xfer  = in_valid & in_ready;

  // S1: capture group summaries on input transfer, drain into S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_nz_q   <= '0;
      s1_li_q   <= '0;
      s1_mode_q <= 1'b0;
    end else begin
      if (in_xfer) begin
        v1_q      <= 1'b1;
        s1_nz_q   <= grp_nz_d;
        s1_li_q   <= grp_li_d;
        s1_mode_q <= mode;
      end else if (s2_load) begin
        v1_q <= 1'b0;
      end
    end
  end

  // S2: load the selected result; hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q      <= 1'b0;
      s2_pos_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_mode_q <= 1'b0;
    end else begin
      if (s2_load) begin
        v2_q      <= 1'b1;
        s2_pos_q  <= sel_pos_d;
        s2_zero_q <= sel_zero_d;
        s2_mode_q <= s1_mode_q;
      end else if (out_ready) begin
        v2_q <= 1'b0;
      end
    end
  end

  assign out_valid   = v2_q;
  assign output_pos  = s2_pos_q;
  assign output_zero = s2_zero_q;
  assign output_mode = s2_mode_q;

endmodule

// File: tb/tb_bit_scan_pipe.sv
// Directed bench for bit_scan_pipe with a scoreboard on the default-width
// instance and a second, narrow instance for the parameter sweep.
module tb_bit_scan_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] input_num = '0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  output_pos;
  logic        output_zero;
  logic        output_mode;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [15:0] s_num = '0;
  logic        s_mode = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [3:0]  s_pos;
  logic        s_zero;
  logic        s_omode;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  bit_scan_pipe #(.N(64), .G(8), .W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_num(input_num), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_pos(output_pos), .output_zero(output_zero), .output_mode(output_mode)
  );

  bit_scan_pipe #(.N(16), .G(4), .W(4)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .input_num(s_num), .mode(s_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .output_pos(s_pos), .output_zero(s_zero), .output_mode(s_omode)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: straight bit walk from the scan end; packs {pos, zero, mode}.
  function automatic logic [9:0] ref_scan(input logic [63:0] w, input logic m);
    logic [7:0] p;
    logic found;
    p = 8'd0;
    found = 1'b0;
    if (!m) begin
      for (int i = 63; i >= 0; i--) begin
        if (!found && w[i]) begin p = 8'(i); found = 1'b1; end
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (!found && w[i]) begin p = 8'(i); found = 1'b1; end
      end
    end
    return {p, ~found, m};
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (sb_q.size() != 0) else begin
          n_bad++;
          $error("FAIL sb_unexpected observed=%0h expected=none", output_pos);
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("sb_pos", 64'(output_pos), 64'(e[9:2]));
          check("sb_zero", 64'(output_zero), 64'(e[1]));
          check("sb_mode", 64'(output_mode), 64'(e[0]));
          $display("out pos=%0d zero=%0d mode=%0d", output_pos, output_zero, output_mode);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(ref_scan(input_num, mode));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w, input logic m);
    input_num = w;
    mode = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] lsb_words [5];
    lsb_words[0] = 64'h0000000000003131;
    lsb_words[1] = 64'h3100000000003131;
    lsb_words[2] = 64'h0000000000000001;
    lsb_words[3] = 64'h8000000000000000;
    lsb_words[4] = 64'h3100000000000000;

    // Reset state.
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pos", 64'(output_pos), 64'd0);
    check("rst_zero", 64'(output_zero), 64'd0);
    check("rst_mode", 64'(output_mode), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // MSB back-to-back, latency and throughput.
    input_num = 64'h0000000000003131; mode = 1'b0; in_valid = 1'b1;
    tick();
    check("lat_not_yet", 64'(out_valid), 64'd0);
    input_num = 64'h3100000000003131;
    tick();
    check("lat_valid", 64'(out_valid), 64'd1);
    check("msb_pos0", 64'(output_pos), 64'd13);
    input_num = 64'h0000000000000001;
    tick();
    check("msb_pos1", 64'(output_pos), 64'd61);
    in_valid = 1'b0;
    tick();
    check("msb_valid2", 64'(out_valid), 64'd1);
    check("msb_pos2", 64'(output_pos), 64'd0);
    tick();
    check("msb_drained", 64'(out_valid), 64'd0);

    // LSB words back-to-back.
    for (int i = 0; i < 5; i++) begin
      input_num = lsb_words[i]; mode = 1'b1; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // All-zero in both modes, then alternating modes.
    send(64'h0, 1'b0);
    send(64'h0, 1'b1);
    send(64'h0000000000003131, 1'b0);
    send(64'h0000000000003131, 1'b1);
    send(64'h8000000000000000, 1'b0);
    repeat (3) tick();

    // Backpressure: two fill the pipe, third waits.
    out_ready = 1'b0;
    input_num = 64'h0000000000003131; mode = 1'b0; in_valid = 1'b1;
    tick();
    check("bp_ready1", 64'(in_ready), 64'd1);
    input_num = 64'h10;
    tick();
    check("bp_full", 64'(in_ready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_pos", 64'(output_pos), 64'd13);
    input_num = 64'h8000000000000000; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_ready", 64'(in_ready), 64'd0);
      check("bp_hold_pos", 64'(output_pos), 64'd13);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_second", 64'(output_pos), 64'd4);
    tick();
    check("bp_third", 64'(output_pos), 64'd63);
    check("bp_third_mode", 64'(output_mode), 64'd1);
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset with the pipe full.
    out_ready = 1'b0;
    send(64'h0000010000000000, 1'b0);
    send(64'h2, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_pos", 64'(output_pos), 64'd0);
    check("mrst_zero", 64'(output_zero), 64'd0);
    check("mrst_mode", 64'(output_mode), 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send(64'h10, 1'b0);
    check("mrst_no_stale", 64'(out_valid), 64'd0);
    tick();
    check("mrst_new_valid", 64'(out_valid), 64'd1);
    check("mrst_new_pos", 64'(output_pos), 64'd4);
    tick();
    check("mrst_empty", 64'(out_valid), 64'd0);

    // Narrow instance: N=16, G=4, W=4.
    s_num = 16'h0800; s_mode = 1'b0; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    tick();
    check("n16_valid", 64'(s_out_valid), 64'd1);
    check("n16_msb", 64'(s_pos), 64'd11);
    check("n16_zero", 64'(s_zero), 64'd0);
    $display("n16 msb pos=%0d", s_pos);
    s_num = 16'h8001; s_mode = 1'b1; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    tick();
    check("n16_lsb", 64'(s_pos), 64'd0);
    check("n16_lsb_mode", 64'(s_omode), 64'd1);
    $display("n16 lsb pos=%0d", s_pos);

    repeat (3) tick();
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
